// File: rtl/rv32_enc_pkg.sv
// Package: rv32_enc_pkg
// Shared constants for the RV32I encoder/loader:
//   - field-bundle format codes (FMT_R .. FMT_J, FMT_BAD)
//   - RV32I major opcode constants
//   - loader FSM state type
//   - imm_fits(): checks that an immediate sign-extends from a given bit
package rv32_enc_pkg;

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_I      = 3'd1;
  localparam logic [2:0] FMT_ISHIFT = 3'd2;
  localparam logic [2:0] FMT_S      = 3'd3;
  localparam logic [2:0] FMT_B      = 3'd4;
  localparam logic [2:0] FMT_U      = 3'd5;
  localparam logic [2:0] FMT_J      = 3'd6;
  localparam logic [2:0] FMT_BAD    = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // True when imm[31:msb] are all equal, i.e. the value is representable
  // as a signed field whose top bit is imm[msb].
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] mask;
    mask = '1 << msb;
    return ((imm & mask) == mask) || ((imm & mask) == '0);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Module: instr_pack
// Combinational RV32I field packer.
// Ports:
//   fmt       in  3   format code (FMT_R .. FMT_J, FMT_BAD)
//   opcode    in  7   placed verbatim in word[6:0]
//   rd/rs1/rs2 in 5   register fields
//   f3        in  3   funct3
//   f7b       in  1   funct7 bit 5 (word bit 30), R and ISHIFT only
//   imm       in  32  full signed byte-offset immediate
//   word      out 32  encoded instruction (0 for FMT_BAD)
//   range_err out 1   immediate not encodable in the format, or FMT_BAD
module instr_pack
  import rv32_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  f3,
  input  logic        f7b,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  always_comb begin
    word      = '0;
    range_err = 1'b0;
    case (fmt)
      FMT_R: begin
        word = {1'b0, f7b, 5'b00000, rs2, rs1, f3, rd, opcode};
      end
      FMT_I: begin
        word      = {imm[11:0], rs1, f3, rd, opcode};
        range_err = !imm_fits(imm, 11);
      end
      FMT_ISHIFT: begin
        word      = {1'b0, f7b, 5'b00000, imm[4:0], rs1, f3, rd, opcode};
        range_err = |imm[31:5];
      end
      FMT_S: begin
        word      = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
        range_err = !imm_fits(imm, 11);
      end
      FMT_B: begin
        word      = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
        range_err = imm[0] | !imm_fits(imm, 12);
      end
      FMT_U: begin
        word      = {imm[31:12], rd, opcode};
        range_err = |imm[11:0];
      end
      FMT_J: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err = imm[0] | !imm_fits(imm, 20);
      end
      default: begin
        word      = '0;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Module: instr_encode_loader
// Accepts RV32I field bundles, packs them (instr_pack) and streams the words
// with sequential word addresses to an instruction-memory write port.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                begin a load (honoured in IDLE/DONE/ERR with out_valid=0)
//   in_valid/in_ready    bundle handshake
//   in_fmt..in_imm       instruction fields
//   in_last              final instruction of the program
//   out_valid/out_ready  memory write handshake
//   out_addr, out_data   word address and encoded instruction
//   busy                 loading in progress
//   done, full, err      sticky status flags
//   err_addr             counter value of the rejected bundle
module instr_encode_loader
  import rv32_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_f3,
  input  logic              in_f7b,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] counter;
  logic [31:0]       packed_word;
  logic              range_err;
  logic              accept;
  logic              start_ok;
  logic              at_max;

  instr_pack u_pack (
    .fmt       (in_fmt),
    .opcode    (in_opcode),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .f3        (in_f3),
    .f7b       (in_f7b),
    .imm       (in_imm),
    .word      (packed_word),
    .range_err (range_err)
  );

  assign in_ready = (state == ST_LOAD) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // A pending write must drain before a new load may restart the counter.
  assign start_ok = start && !out_valid && (state != ST_LOAD);
  assign at_max   = (counter == CNT_MAX);
  assign busy     = (state == ST_LOAD);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_ok) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (range_err)               state_nx = ST_ERR;
          else if (in_last || at_max)  state_nx = ST_DONE;
        end
      end
      ST_DONE: if (start_ok) state_nx = ST_LOAD;
      ST_ERR:  if (start_ok) state_nx = ST_LOAD;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      counter   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      state <= state_nx;

      if (start_ok) begin
        counter  <= '0;
        done     <= 1'b0;
        full     <= 1'b0;
        err      <= 1'b0;
        err_addr <= '0;
      end

      if (accept && !range_err) begin
        out_data  <= packed_word;
        out_addr  <= counter;
        out_valid <= 1'b1;
        // Counter saturates at the last slot; the FSM leaves LOAD there anyway.
        if (!at_max) counter <= counter + 1'b1;
        if (in_last || at_max) done <= 1'b1;
        if (at_max && !in_last) full <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && range_err) begin
        err      <= 1'b1;
        err_addr <= counter;
      end
    end
  end

endmodule
